rob_commit_unit: RTL and testbench

In-order reorder buffer and commit stage. It sits at the retire end of the decode/rename path and produces the commit_valid / commit_with_write / commited_wr_register / flush signals that the rename stage uses to free physical registers and squash. Decode allocates one entry per renamed instruction. Execute marks entries complete. The head entry retires once complete. A mispredicted branch at the head retires and then flushes the whole window.

---
 rtl/rob_commit_unit_pkg.sv | 34 +++
 rtl/rob_ptr.sv | 31 +++
 rtl/rob_commit_unit.sv | 165 ++++++++++++++++
 tb/tb_rob_commit_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_unit_pkg.sv
// Shared types and sizing for the reorder buffer / commit stage.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif

package rob_commit_unit_pkg;

  localparam int unsigned RC_DEPTH  = `ROB_DEPTH;
  localparam int unsigned RC_IDX_W  = $clog2(RC_DEPTH);
  localparam int unsigned RC_PREG_W = `PHYSICAL_REG_NUM_WIDTH;
  localparam int unsigned RC_ADDR_W = `INST_ADDR_WIDTH;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 with_write;
    logic [RC_PREG_W-1:0] free_reg;
    logic                 is_branch;
    logic                 mispredict;
    logic [RC_ADDR_W-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer with synchronous active-low clear and increment enable.
module rob_ptr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: clear wins over increment; natural wrap at 2^W.
  always_comb begin
    ptr_d = ptr_q;
    if (!clr_n) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer with single-retire commit and branch-mispredict flush.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int unsigned ROB_DEPTH              = `ROB_DEPTH,
  parameter int unsigned ROB_IDX_WIDTH          = $clog2(ROB_DEPTH),
  parameter int unsigned PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
  parameter int unsigned INST_ADDR_WIDTH        = `INST_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  input  logic                              alloc_with_write,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_free_reg,
  input  logic                              alloc_is_branch,
  output logic                              alloc_ready,
  output logic [ROB_IDX_WIDTH-1:0]          alloc_tag,
  input  logic                              complete_valid,
  input  logic [ROB_IDX_WIDTH-1:0]          complete_tag,
  input  logic                              complete_mispredict,
  input  logic [INST_ADDR_WIDTH-1:0]        complete_target,
  output logic                              commit_valid,
  output logic                              commit_with_write,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  output logic                              flush,
  output logic [INST_ADDR_WIDTH-1:0]        flush_pc,
  output logic                              rob_empty,
  output logic [ROB_IDX_WIDTH:0]            rob_count
);

  localparam int unsigned CNT_W = ROB_IDX_WIDTH + 1;

  rob_state_t                        state_q, state_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  rob_entry_t                        entry_q [ROB_DEPTH];
  rob_entry_t                        entry_d [ROB_DEPTH];
  logic                              commit_valid_q, commit_valid_d;
  logic                              commit_with_write_q, commit_with_write_d;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register_q, commited_wr_register_d;
  logic                              flush_q, flush_d;
  logic [INST_ADDR_WIDTH-1:0]        flush_pc_q, flush_pc_d;

  logic [ROB_IDX_WIDTH-1:0] head;
  logic [ROB_IDX_WIDTH-1:0] tail;
  rob_entry_t               head_e;
  logic                     alloc_fire;
  logic                     comp_fire;
  logic                     retire;
  logic                     mis_retire;
  logic                     ptr_clr_n;

  // Handshake and retire decisions, all from registered state.
  always_comb begin
    head_e      = entry_q[head];
    alloc_ready = (state_q == RUN) && (count_q < CNT_W'(ROB_DEPTH));
    alloc_fire  = alloc_valid && alloc_ready;
    comp_fire   = complete_valid && (state_q == RUN) && entry_q[complete_tag].valid;
    retire      = (state_q == RUN) && head_e.valid && head_e.done;
    mis_retire  = retire && head_e.is_branch && head_e.mispredict;
    ptr_clr_n   = reset && !mis_retire;
  end

  rob_ptr #(.W(ROB_IDX_WIDTH)) u_head (
    .clk   (clk),
    .clr_n (ptr_clr_n),
    .inc   (retire),
    .ptr   (head)
  );

  rob_ptr #(.W(ROB_IDX_WIDTH)) u_tail (
    .clk   (clk),
    .clr_n (ptr_clr_n),
    .inc   (alloc_fire),
    .ptr   (tail)
  );

  // Next state: FSM, occupancy, entry array and commit/flush outputs.
  always_comb begin
    state_d                = state_q;
    count_d                = count_q;
    entry_d                = entry_q;
    commit_valid_d         = retire;
    commit_with_write_d    = retire && head_e.with_write;
    commited_wr_register_d = (retire && head_e.with_write) ? head_e.free_reg : '0;
    flush_d                = mis_retire;
    flush_pc_d             = mis_retire ? head_e.target : '0;

    unique case (state_q)
      RUN:     if (mis_retire) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    unique case ({alloc_fire, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (alloc_fire) begin
      entry_d[tail].valid      = 1'b1;
      entry_d[tail].done       = 1'b0;
      entry_d[tail].with_write = alloc_with_write;
      entry_d[tail].free_reg   = alloc_free_reg;
      entry_d[tail].is_branch  = alloc_is_branch;
      entry_d[tail].mispredict = 1'b0;
      entry_d[tail].target     = '0;
    end

    // A re-completion simply overwrites the outcome fields.
    if (comp_fire) begin
      entry_d[complete_tag].done       = 1'b1;
      entry_d[complete_tag].mispredict = complete_mispredict;
      entry_d[complete_tag].target     = complete_target;
    end

    if (retire) begin
      entry_d[head].valid = 1'b0;
    end

    // Mispredict squashes the whole window, including a same-cycle allocation.
    if (mis_retire) begin
      count_d = '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_d[i].valid = 1'b0;
        entry_d[i].done  = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q                <= RUN;
      count_q                <= '0;
      commit_valid_q         <= 1'b0;
      commit_with_write_q    <= 1'b0;
      commited_wr_register_q <= '0;
      flush_q                <= 1'b0;
      flush_pc_q             <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      state_q                <= state_d;
      count_q                <= count_d;
      commit_valid_q         <= commit_valid_d;
      commit_with_write_q    <= commit_with_write_d;
      commited_wr_register_q <= commited_wr_register_d;
      flush_q                <= flush_d;
      flush_pc_q             <= flush_pc_d;
      entry_q                <= entry_d;
    end
  end

  assign alloc_tag            = tail;
  assign rob_count            = count_q;
  assign rob_empty            = (count_q == '0);
  assign commit_valid         = commit_valid_q;
  assign commit_with_write    = commit_with_write_q;
  assign commited_wr_register = commited_wr_register_q;
  assign flush                = flush_q;
  assign flush_pc             = flush_pc_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed plus randomized bench for rob_commit_unit against a queue-based model.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  localparam int unsigned D  = RC_DEPTH;
  localparam int unsigned IW = RC_IDX_W;
  localparam int unsigned PW = RC_PREG_W;
  localparam int unsigned AW = RC_ADDR_W;

  logic          clk;
  logic          reset;
  logic          alloc_valid;
  logic          alloc_with_write;
  logic [PW-1:0] alloc_free_reg;
  logic          alloc_is_branch;
  logic          alloc_ready;
  logic [IW-1:0] alloc_tag;
  logic          complete_valid;
  logic [IW-1:0] complete_tag;
  logic          complete_mispredict;
  logic [AW-1:0] complete_target;
  logic          commit_valid;
  logic          commit_with_write;
  logic [PW-1:0] commited_wr_register;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          rob_empty;
  logic [IW:0]   rob_count;

  rob_commit_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_with_write     (alloc_with_write),
    .alloc_free_reg       (alloc_free_reg),
    .alloc_is_branch      (alloc_is_branch),
    .alloc_ready          (alloc_ready),
    .alloc_tag            (alloc_tag),
    .complete_valid       (complete_valid),
    .complete_tag         (complete_tag),
    .complete_mispredict  (complete_mispredict),
    .complete_target      (complete_target),
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .flush                (flush),
    .flush_pc             (flush_pc),
    .rob_empty            (rob_empty),
    .rob_count            (rob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-flight instructions oldest-first; presence in the queue means valid.
  typedef struct {
    logic [IW-1:0] tag;
    bit            ww;
    logic [PW-1:0] freg;
    bit            br;
    bit            done;
    bit            mis;
    logic [AW-1:0] tgt;
  } m_ent_t;

  m_ent_t        mq[$];
  int            m_tail;
  bit            m_flush;
  bit            e_cv, e_cw, e_fl;
  logic [PW-1:0] e_reg;
  logic [AW-1:0] e_fpc;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge as the specification describes it, in transaction terms.
  task automatic model_step();
    bit     ready, alloc, ret, mis;
    m_ent_t ne;
    if (!reset) begin
      mq.delete();
      m_tail = 0; m_flush = 0;
      e_cv = 0; e_cw = 0; e_reg = '0; e_fl = 0; e_fpc = '0;
      return;
    end
    ready = !m_flush && (mq.size() < int'(D));
    alloc = alloc_valid && ready;
    ret   = !m_flush && (mq.size() > 0) && mq[0].done;
    mis   = ret && mq[0].br && mq[0].mis;
    e_cv  = ret;
    e_cw  = ret && mq[0].ww;
    e_reg = (ret && mq[0].ww) ? mq[0].freg : '0;
    e_fl  = mis;
    e_fpc = mis ? mq[0].tgt : '0;
    if (complete_valid && !m_flush) begin
      foreach (mq[i]) begin
        if (mq[i].tag == complete_tag) begin
          mq[i].done = 1; mq[i].mis = complete_mispredict; mq[i].tgt = complete_target;
        end
      end
    end
    if (mis) begin
      mq.delete();
      m_tail = 0; m_flush = 1;
    end else begin
      m_flush = 0;
      if (ret) void'(mq.pop_front());
      if (alloc) begin
        ne.tag = IW'(m_tail); ne.ww = alloc_with_write; ne.freg = alloc_free_reg;
        ne.br = alloc_is_branch; ne.done = 0; ne.mis = 0; ne.tgt = '0;
        mq.push_back(ne);
        m_tail = (m_tail + 1) % int'(D);
      end
    end
  endtask

  task automatic check_all();
    chk("alloc_ready", 64'(alloc_ready), 64'(!m_flush && (mq.size() < int'(D))));
    chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    chk("rob_count", 64'(rob_count), 64'(mq.size()));
    chk("rob_empty", 64'(rob_empty), 64'(mq.size() == 0));
    chk("commit_valid", 64'(commit_valid), 64'(e_cv));
    chk("commit_with_write", 64'(commit_with_write), 64'(e_cw));
    chk("commited_wr_register", 64'(commited_wr_register), 64'(e_reg));
    chk("flush", 64'(flush), 64'(e_fl));
    chk("flush_pc", 64'(flush_pc), 64'(e_fpc));
  endtask

  // Inputs change only after the falling edge; outputs are checked there.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_with_write = 0; alloc_free_reg = '0; alloc_is_branch = 0;
    complete_valid = 0; complete_tag = '0; complete_mispredict = 0; complete_target = '0;
  endtask

  task automatic set_alloc(input bit ww, input int freg, input bit br);
    alloc_valid = 1; alloc_with_write = ww; alloc_free_reg = PW'(freg); alloc_is_branch = br;
  endtask

  task automatic set_comp(input int tag, input bit mis, input int tgt);
    complete_valid = 1; complete_tag = IW'(tag); complete_mispredict = mis;
    complete_target = AW'(tgt);
  endtask

  task automatic do_reset(input int cycles);
    idle();
    reset = 0;
    for (int i = 0; i < cycles; i++) step();
    reset = 1;
  endtask

  initial begin
    idle();
    reset = 0;

    // Reset held two cycles.
    do_reset(2);
    chk("rst_empty", 64'(rob_empty), 64'(1));
    chk("rst_count", 64'(rob_count), 64'(0));
    chk("rst_ready", 64'(alloc_ready), 64'(1));
    chk("rst_commit", 64'(commit_valid), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));

    // Basic in-order retire with out-of-order completion.
    set_alloc(1, 5, 0); step();
    set_alloc(0, 6, 0); step();
    set_alloc(1, 7, 0); step();
    idle(); set_comp(2, 0, 0); step();
    idle(); set_comp(0, 0, 0); step();
    chk("lat_early", 64'(commit_valid), 64'(0));
    idle(); set_comp(1, 0, 0); step();
    chk("ret0_valid", 64'(commit_valid), 64'(1));
    chk("ret0_reg", 64'(commited_wr_register), 64'(5));
    idle(); step();
    chk("ret1_valid", 64'(commit_valid), 64'(1));
    chk("ret1_ww", 64'(commit_with_write), 64'(0));
    chk("ret1_reg", 64'(commited_wr_register), 64'(0));
    step();
    chk("ret2_valid", 64'(commit_valid), 64'(1));
    chk("ret2_reg", 64'(commited_wr_register), 64'(7));
    step();
    chk("drained", 64'(rob_count), 64'(0));

    // Fill to full, reject an extra, retire two, then allocate with wrapped tags.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      set_alloc(i[0], i + 16, 0); step();
    end
    chk("full_ready", 64'(alloc_ready), 64'(0));
    chk("full_count", 64'(rob_count), 64'(16));
    set_alloc(1, 3, 0); step();
    chk("full_reject", 64'(rob_count), 64'(16));
    idle(); set_comp(0, 0, 0); step();
    idle(); set_comp(1, 0, 0); step();
    idle(); step();
    step();
    chk("after_two_count", 64'(rob_count), 64'(14));
    chk("wrap_tag0", 64'(alloc_tag), 64'(0));
    set_alloc(1, 1, 0); step();
    chk("wrap_tag1", 64'(alloc_tag), 64'(1));
    set_alloc(1, 2, 0); step();
    idle();
    chk("refull_count", 64'(rob_count), 64'(16));

    // Mispredicted branch at head; allocation in the decision cycle is dropped.
    do_reset(1);
    set_alloc(0, 0, 1); step();
    set_alloc(1, 9, 0); step();
    set_alloc(1, 10, 0); step();
    set_alloc(1, 11, 0); step();
    idle(); set_comp(0, 1, 'h40); step();
    idle(); set_alloc(1, 12, 0); step();
    chk("mp_commit", 64'(commit_valid), 64'(1));
    chk("mp_flush", 64'(flush), 64'(1));
    chk("mp_pc", 64'(flush_pc), 64'('h40));
    chk("mp_ready", 64'(alloc_ready), 64'(0));
    idle(); set_comp(1, 0, 0); step();
    idle();
    chk("mp_count", 64'(rob_count), 64'(0));
    chk("mp_tag", 64'(alloc_tag), 64'(0));
    chk("mp_flush_end", 64'(flush), 64'(0));

    // Completion of an unallocated tag is ignored.
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, i + 20, 0); step();
    end
    idle(); set_comp(9, 1, 'h99); step();
    idle(); step(); step();
    chk("bad_commit", 64'(commit_valid), 64'(0));
    chk("bad_count", 64'(rob_count), 64'(3));

    // Reset while five are in flight and two non-head entries are done.
    set_alloc(1, 30, 0); step();
    set_alloc(1, 31, 0); step();
    idle(); set_comp(1, 0, 0); step();
    idle(); set_comp(2, 0, 0); step();
    idle();
    chk("pre_rst_count", 64'(rob_count), 64'(5));
    do_reset(1);
    chk("midrst_commit0", 64'(commit_valid), 64'(0));
    step();
    chk("midrst_commit1", 64'(commit_valid), 64'(0));
    chk("midrst_count", 64'(rob_count), 64'(0));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) < 6)
        set_alloc(1'($urandom()), int'($urandom_range(0, 63)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        if (mq.size() > 0 && $urandom_range(0, 9) < 8)
          set_comp(int'(mq[$urandom_range(0, mq.size() - 1)].tag),
                   $urandom_range(0, 7) == 0, int'($urandom()));
        else
          set_comp(int'($urandom_range(0, D - 1)), $urandom_range(0, 7) == 0,
                   int'($urandom()));
      end
      step();
    end
    idle();
    reset = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
